// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port plus the redirect input
// and the {pc, instr} valid/ready channel towards decode.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 32
);
  logic [ADDR_WIDTH-1:0]   o_imem_addr;
  logic [DATA_WIDTH-1:0]   o_imem_wdata;
  logic [DATA_WIDTH/8-1:0] o_imem_wen;
  logic [DATA_WIDTH-1:0]   i_imem_rdata;
  logic                    i_redirect;
  logic [PC_WIDTH-1:0]     i_redirect_pc;
  logic                    o_valid;
  logic                    i_ready;
  logic [PC_WIDTH-1:0]     o_pc;
  logic [31:0]             o_instr;

  // Fetch stage side
  modport master (
    output o_imem_addr, o_imem_wdata, o_imem_wen,
    input  i_imem_rdata,
    input  i_redirect, i_redirect_pc,
    output o_valid, o_pc, o_instr,
    input  i_ready
  );

  // Memory / decode / control side
  modport slave (
    input  o_imem_addr, o_imem_wdata, o_imem_wen,
    output i_imem_rdata,
    output i_redirect, i_redirect_pc,
    input  o_valid, o_pc, o_instr,
    output i_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses a 64-bit synchronous-read
// instruction memory, picks the 32-bit half of each returned word and hands
// {pc, instr} to decode through a 2-entry FIFO that absorbs the one-cycle
// memory latency under backpressure. A redirect flushes and restarts fetch.
module instr_fetch #(
  parameter int                  ADDR_WIDTH = 11,
  parameter int                  DATA_WIDTH = 64,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}}
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);

  localparam logic [PC_WIDTH-1:0] PC_STEP  = {{(PC_WIDTH-3){1'b0}}, 3'd4};
  localparam logic [PC_WIDTH-1:0] PC_ALIGN = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  // Architectural state
  logic [PC_WIDTH-1:0] fetch_pc_r;
  logic                inflight_r;
  logic [PC_WIDTH-1:0] inflight_pc_r;
  logic [1:0]          count_r;
  logic [PC_WIDTH-1:0] head_pc_r;
  logic [31:0]         head_instr_r;
  logic [PC_WIDTH-1:0] tail_pc_r;
  logic [31:0]         tail_instr_r;

  // Combinational control
  logic [PC_WIDTH-1:0] req_pc_s;
  logic                pop_s;
  logic                push_s;
  logic                issue_s;
  logic [2:0]          occ_s;
  logic [31:0]         push_instr_s;
  logic [1:0]          count_nxt_s;
  logic [PC_WIDTH-1:0] head_pc_nxt_s;
  logic [31:0]         head_instr_nxt_s;
  logic [PC_WIDTH-1:0] tail_pc_nxt_s;
  logic [31:0]         tail_instr_nxt_s;

  // Memory is read-only from this stage; entries beyond count stay zero so
  // the head registers drive pc/instr = 0 whenever the FIFO is empty.
  assign bus.o_imem_addr  = req_pc_s[ADDR_WIDTH+2:3];
  assign bus.o_imem_wdata = {DATA_WIDTH{1'b0}};
  assign bus.o_imem_wen   = {(DATA_WIDTH/8){1'b0}};
  assign bus.o_valid      = (count_r != 2'd0);
  assign bus.o_pc         = head_pc_r;
  assign bus.o_instr      = head_instr_r;

  // Request address, handshake and issue decision for this cycle
  always_comb begin
    req_pc_s     = fetch_pc_r;
    push_instr_s = bus.i_imem_rdata[31:0];
    if (bus.i_redirect) begin
      req_pc_s = bus.i_redirect_pc & PC_ALIGN;
    end else begin
      req_pc_s = fetch_pc_r;
    end
    if (inflight_pc_r[2]) begin
      push_instr_s = bus.i_imem_rdata[DATA_WIDTH-1:32];
    end else begin
      push_instr_s = bus.i_imem_rdata[31:0];
    end
    pop_s   = (count_r != 2'd0) && bus.i_ready;
    push_s  = inflight_r && !bus.i_redirect;
    occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s = bus.i_redirect || (occ_s < 3'd2);
  end

  // FIFO next state: head is always entry 0, vacated slots are zeroed
  always_comb begin
    count_nxt_s      = count_r;
    head_pc_nxt_s    = head_pc_r;
    head_instr_nxt_s = head_instr_r;
    tail_pc_nxt_s    = tail_pc_r;
    tail_instr_nxt_s = tail_instr_r;
    if (bus.i_redirect) begin
      count_nxt_s      = 2'd0;
      head_pc_nxt_s    = {PC_WIDTH{1'b0}};
      head_instr_nxt_s = 32'h0;
      tail_pc_nxt_s    = {PC_WIDTH{1'b0}};
      tail_instr_nxt_s = 32'h0;
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          if (count_r == 2'd1) begin
            head_pc_nxt_s    = inflight_pc_r;
            head_instr_nxt_s = push_instr_s;
          end else begin
            head_pc_nxt_s    = tail_pc_r;
            head_instr_nxt_s = tail_instr_r;
            tail_pc_nxt_s    = inflight_pc_r;
            tail_instr_nxt_s = push_instr_s;
          end
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            head_pc_nxt_s    = inflight_pc_r;
            head_instr_nxt_s = push_instr_s;
          end else begin
            tail_pc_nxt_s    = inflight_pc_r;
            tail_instr_nxt_s = push_instr_s;
          end
          count_nxt_s = count_r + 2'd1;
        end
        2'b01: begin
          head_pc_nxt_s    = tail_pc_r;
          head_instr_nxt_s = tail_instr_r;
          tail_pc_nxt_s    = {PC_WIDTH{1'b0}};
          tail_instr_nxt_s = 32'h0;
          count_nxt_s      = count_r - 2'd1;
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // PC, in-flight tracking and FIFO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {PC_WIDTH{1'b0}};
      count_r       <= 2'd0;
      head_pc_r     <= {PC_WIDTH{1'b0}};
      head_instr_r  <= 32'h0;
      tail_pc_r     <= {PC_WIDTH{1'b0}};
      tail_instr_r  <= 32'h0;
    end else begin
      if (issue_s) begin
        inflight_r    <= 1'b1;
        inflight_pc_r <= req_pc_s;
        fetch_pc_r    <= req_pc_s + PC_STEP;
      end else begin
        inflight_r    <= 1'b0;
      end
      count_r      <= count_nxt_s;
      head_pc_r    <= head_pc_nxt_s;
      head_instr_r <= head_instr_nxt_s;
      tail_pc_r    <= tail_pc_nxt_s;
      tail_instr_r <= tail_instr_nxt_s;
    end
  end

  // The issue rule must keep a push from ever landing on a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_s && !pop_s && (count_r == 2'd2)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: streaming, backpressure, redirects,
// PC/word-address wrap and asynchronous mid-stream reset.
module tb_instr_fetch;

  logic clk;
  logic rst;
  logic rst2;

  logic [63:0] mem [0:2047];
  logic [64:0] obs;
  logic [64:0] exp;
  int          total;
  int          passed;

  instr_fetch_if #(.ADDR_WIDTH(11), .DATA_WIDTH(64), .PC_WIDTH(32)) bus ();
  instr_fetch_if #(.ADDR_WIDTH(11), .DATA_WIDTH(64), .PC_WIDTH(32)) bus2 ();

  instr_fetch #(.ADDR_WIDTH(11), .DATA_WIDTH(64), .PC_WIDTH(32),
                .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch #(.ADDR_WIDTH(11), .DATA_WIDTH(64), .PC_WIDTH(32),
                .RESET_PC(32'h0000_3FFC)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory models
  always @(posedge clk) bus.i_imem_rdata <= mem[bus.o_imem_addr];
  always @(posedge clk) bus2.i_imem_rdata <= mem[bus2.o_imem_addr];

  task automatic do_reset(input logic rdy);
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_ready       = rdy;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'h0; bus.i_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b0, 32'h0, 32'h0}; total++;
    if (obs !== exp) $display("FAIL reset_outputs: got %h exp %h", obs, exp); else passed++;
    total++;
    if ({bus.o_imem_wen, bus.o_imem_wdata} !== 72'h0) $display("FAIL reset_wr_tied: got %h exp 0", {bus.o_imem_wen, bus.o_imem_wdata}); else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (bus.o_imem_addr !== 11'h000) $display("FAIL reset_addr: got %h exp 000", bus.o_imem_addr); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b0, 32'h0, 32'h0}; total++;
    if (obs !== exp) $display("FAIL latency_cycle1: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h0, 32'h0000_0013}; total++;
    if (obs !== exp) $display("FAIL latency_cycle2: got %h exp %h", obs, exp); else passed++;
  endtask

  task automatic test_stream;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h4, 32'h0050_0093}; total++;
    if (obs !== exp) $display("FAIL stream_pc4: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h8, 32'h00A0_0193}; total++;
    if (obs !== exp) $display("FAIL stream_pc8: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'hC, 32'h0010_8113}; total++;
    if (obs !== exp) $display("FAIL stream_pcC: got %h exp %h", obs, exp); else passed++;
  endtask

  task automatic test_backpressure;
    do_reset(1'b1);
    @(negedge clk);
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h0, 32'h0000_0013}; total++;
    if (obs !== exp) $display("FAIL bp_first: got %h exp %h", obs, exp); else passed++;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h0, 32'h0000_0013}; total++;
      if (obs !== exp) $display("FAIL bp_hold%0d: got %h exp %h", i, obs, exp); else passed++;
      total++;
      if (bus.o_imem_addr !== 11'h001) $display("FAIL bp_addr%0d: got %h exp 001", i, bus.o_imem_addr); else passed++;
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h4, 32'h0050_0093}; total++;
    if (obs !== exp) $display("FAIL bp_rel_pc4: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h8, 32'h00A0_0193}; total++;
    if (obs !== exp) $display("FAIL bp_rel_pc8: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'hC, 32'h0010_8113}; total++;
    if (obs !== exp) $display("FAIL bp_rel_pcC: got %h exp %h", obs, exp); else passed++;
  endtask

  task automatic test_redirect_full;
    do_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h0, 32'h0000_0013}; total++;
    if (obs !== exp) $display("FAIL rdf_full_head: got %h exp %h", obs, exp); else passed++;
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0106;
    #1;
    total++;
    if (bus.o_imem_addr !== 11'h020) $display("FAIL rdf_addr: got %h exp 020", bus.o_imem_addr); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b0, 32'h0, 32'h0}; total++;
    if (obs !== exp) $display("FAIL rdf_flushed: got %h exp %h", obs, exp); else passed++;
    bus.i_redirect = 1'b0; bus.i_ready = 1'b1;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h104, 32'hB100_0020}; total++;
    if (obs !== exp) $display("FAIL rdf_pc104: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h108, 32'hA000_0021}; total++;
    if (obs !== exp) $display("FAIL rdf_pc108: got %h exp %h", obs, exp); else passed++;
  endtask

  task automatic test_redirect_pop;
    do_reset(1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h4, 32'h0050_0093}; total++;
    if (obs !== exp) $display("FAIL rdp_before: got %h exp %h", obs, exp); else passed++;
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0200;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b0, 32'h0, 32'h0}; total++;
    if (obs !== exp) $display("FAIL rdp_flushed: got %h exp %h", obs, exp); else passed++;
    bus.i_redirect = 1'b0;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h200, 32'hA000_0040}; total++;
    if (obs !== exp) $display("FAIL rdp_pc200: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h204, 32'hB100_0040}; total++;
    if (obs !== exp) $display("FAIL rdp_pc204: got %h exp %h", obs, exp); else passed++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h208, 32'hA000_0041}; total++;
    if (obs !== exp) $display("FAIL mid_pre: got %h exp %h", obs, exp); else passed++;
    #2 rst = 1'b1;
    #1;
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b0, 32'h0, 32'h0}; total++;
    if (obs !== exp) $display("FAIL mid_async: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b0, 32'h0, 32'h0}; total++;
    if (obs !== exp) $display("FAIL mid_cycle1: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus.o_valid, bus.o_pc, bus.o_instr}; exp = {1'b1, 32'h0, 32'h0000_0013}; total++;
    if (obs !== exp) $display("FAIL mid_restart: got %h exp %h", obs, exp); else passed++;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    total++;
    if (bus2.o_imem_addr !== 11'h7FF) $display("FAIL wrap_addr0: got %h exp 7ff", bus2.o_imem_addr); else passed++;
    @(negedge clk);
    total++;
    if ({bus2.o_valid, bus2.o_imem_addr} !== {1'b0, 11'h000}) $display("FAIL wrap_addr1: got %h exp 000", {bus2.o_valid, bus2.o_imem_addr}); else passed++;
    @(negedge clk);
    obs = {bus2.o_valid, bus2.o_pc, bus2.o_instr}; exp = {1'b1, 32'h3FFC, 32'hB100_07FF}; total++;
    if (obs !== exp) $display("FAIL wrap_pc3ffc: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus2.o_valid, bus2.o_pc, bus2.o_instr}; exp = {1'b1, 32'h4000, 32'h0000_0013}; total++;
    if (obs !== exp) $display("FAIL wrap_pc4000: got %h exp %h", obs, exp); else passed++;
    @(negedge clk);
    obs = {bus2.o_valid, bus2.o_pc, bus2.o_instr}; exp = {1'b1, 32'h4004, 32'h0050_0093}; total++;
    if (obs !== exp) $display("FAIL wrap_pc4004: got %h exp %h", obs, exp); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] w;
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    rst2   = 1'b1;
    bus2.i_redirect = 1'b0; bus2.i_redirect_pc = 32'h0; bus2.i_ready = 1'b1;
    mem[0] = 64'h00500093_00000013;
    mem[1] = 64'h00108113_00A00193;
    for (int i = 2; i < 2048; i++) begin
      w = 11'(i);
      mem[i] = {8'hB1, 13'h0, w, 8'hA0, 13'h0, w};
    end
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_full;
    test_redirect_pop;
    test_reset_mid;
    test_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the 64-bit synchronous-read instruction memory.
- Owns the PC and drives the memory word address every cycle.
- Selects the 32-bit instruction half from each returned 64-bit word and presents {pc, instr} to decode over a valid/ready handshake.
- A 2-entry output FIFO absorbs the 1-cycle memory latency under backpressure; a redirect input (branch/jump/trap) flushes and restarts fetch.

Parameters:
- ADDR_WIDTH, 11, imem word-address width (2048 x 64-bit words).
- DATA_WIDTH, 64, imem word width; fixed at 64 (two 32-bit instructions per word).
- PC_WIDTH, 32, program counter width.
- RESET_PC, 0, byte address fetched first after reset.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- o_imem_addr  out  ADDR_WIDTH  imem word address = req_pc[ADDR_WIDTH+2:3].
- o_imem_wdata  out  DATA_WIDTH  tied to 0.
- o_imem_wen  out  DATA_WIDTH/8  tied to 0.
- i_imem_rdata  in  DATA_WIDTH  imem data; valid the cycle after the address was driven.
- i_redirect  in  1  flush and restart fetch at i_redirect_pc.
- i_redirect_pc  in  PC_WIDTH  new fetch byte address; bits [1:0] ignored (forced 0).
- o_valid  out  1  o_pc/o_instr hold a valid instruction.
- i_ready  in  1  decode accepts; transfer when o_valid && i_ready.
- o_pc  out  PC_WIDTH  byte address of o_instr.
- o_instr  out  32  fetched instruction.

Behaviour:
- State:
  - fetch_pc: next byte address to request.
  - inflight (1 bit) plus inflight_pc: request issued last cycle.
  - FIFO: 2 entries of {pc, instr}, with count 0..2.
  - Outputs are driven from the FIFO head: o_valid = (count != 0).
- Reset (async, any time, including mid-operation):
  - fetch_pc = RESET_PC; inflight = 0; count = 0.
  - o_valid = 0; o_pc = 0 and o_instr = 0 while empty.
- Issue rule:
  - pop = o_valid && i_ready.
  - A request is issued in a cycle iff (count + inflight - pop) < 2, or i_redirect = 1.
  - Issuing drives o_imem_addr from req_pc, sets inflight = 1 with inflight_pc = req_pc, and sets fetch_pc = req_pc + 4.
  - Otherwise inflight = 0, and o_imem_addr holds the fetch_pc word (harmless, the read is ignored).
- req_pc = i_redirect ? {i_redirect_pc[PC_WIDTH-1:2], 2'b00} : fetch_pc.
- Response handling (cycle after issue):
  - If inflight and no redirect this cycle, push {inflight_pc, inflight_pc[2] ? rdata[63:32] : rdata[31:0]}.
  - Push and pop in the same cycle are allowed; the FIFO never overflows (guaranteed by the issue rule, assert in sim).
- Redirect:
  - Takes priority over everything.
  - FIFO cleared (count = 0) and inflight response discarded.
  - A new request at req_pc is issued in the same cycle.
  - o_valid = 0 in cycle T+1 and 1 in cycle T+2 (redirect in T). An instruction presented in cycle T is not considered transferred even if i_ready = 1.
- Latency: first o_valid 2 cycles after rst deasserts. Sustained throughput is 1 instruction/cycle with i_ready held high.
- Backpressure: with i_ready = 0 the head entry is held stable (o_pc, o_instr unchanged) until accepted. Issue stops once count + inflight = 2.
- Wrap-around: fetch_pc wraps modulo 2^PC_WIDTH. The imem address wraps modulo 2^ADDR_WIDTH words (PC bits above ADDR_WIDTH+2 are ignored).
- Order: instructions are delivered strictly in PC order, consecutive +4, except across a redirect.

Test Plan:
- Reset then i_ready = 1, imem word0 = 0x00500093_00000013, word1 = 0x00108113_00A00193 -> o_valid first high in cycle 2.
  - Delivered: (pc 0x0, 0x00000013), (0x4, 0x00500093), (0x8, 0x00A00193), (0xC, 0x00108113), one per cycle.
- i_ready low for 5 cycles after the first valid -> o_pc = 0x0 held stable; o_imem_addr stops advancing with count = 2.
  - On release, 0x0, 0x4, 0x8 are delivered back-to-back with no gap or duplicate.
- Redirect to 0x106 while FIFO is full and a request is inflight -> nothing stale is delivered.
  - Two cycles later, pc 0x104 = upper half of word 0x20; next pc is 0x108.
- Redirect asserted in the same cycle as a pop -> popped entry discarded; next delivered pc equals the redirect target.
- RESET_PC = 0x3FFC with ADDR_WIDTH = 11 -> first pc 0x3FFC reads word 0x7FF upper half.
  - Next pc 0x4000 reads word 0x000 lower half.
- rst asserted mid-stream with o_valid = 1 -> o_valid drops immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.
